// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: load-use stalls, taken-branch flushes and data-memory wait states with timeout.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] drs,
  input  logic [4:0] drt,
  input  logic       duse_rs,
  input  logic       duse_rt,
  input  logic       dbranch_taken,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] ern,
  input  logic       mreq,
  input  logic       mrdy,
  output logic       pc_en,
  output logic       fd_en,
  output logic       fd_flush,
  output logic       de_bubble,
  output logic       em_en,
  output logic       mw_bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_lu_stall,
  output logic [31:0] perf_flush,
`endif
  output logic       mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERROR} mstate_t;

  mstate_t          state;
  logic [CNT_W-1:0] wcnt;
  logic             mem_stall;
  logic             lu_stall;
  logic             rs_hit;
  logic             rt_hit;

  // wcnt counts WAIT cycles already spent; the access fails once MEM_TIMEOUT of them pass without mrdy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mreq && !mrdy) begin
            state <= S_WAIT;
            wcnt  <= CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (mrdy) begin
            state <= S_IDLE;
            wcnt  <= '0;
          end else if (wcnt == CNT_W'(MEM_TIMEOUT)) begin
            state   <= S_ERROR;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_stall = ((state == S_IDLE) && mreq && !mrdy) ||
                     ((state == S_WAIT) && !mrdy) ||
                     (state == S_ERROR);

  assign rs_hit   = duse_rs && (ern == drs);
  assign rt_hit   = duse_rt && (ern == drt);
  assign lu_stall = ewreg && em2reg && (ern != 5'd0) && (rs_hit || rt_hit);

  // A branch seen during any stall is dropped; ID is held so it re-resolves next cycle.
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    em_en     = 1'b1;
    mw_bubble = 1'b0;
    if (reset) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
      em_en     = 1'b0;
      mw_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      em_en     = 1'b0;
      mw_bubble = 1'b1;
    end else if (lu_stall) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_bubble = 1'b1;
    end else if (dbranch_taken) begin
      fd_flush  = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_mem_stall <= '0;
      perf_lu_stall  <= '0;
      perf_flush     <= '0;
    end else begin
      if (mem_stall && (perf_mem_stall != '1))
        perf_mem_stall <= perf_mem_stall + 32'd1;
      if (lu_stall && !mem_stall && (perf_lu_stall != '1))
        perf_lu_stall <= perf_lu_stall + 32'd1;
      if (fd_flush && (perf_flush != '1))
        perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule
